// File: rtl/dft_stream.sv
// -----------------------------------------------------------------------------
// dft_stream
//   Streaming direct DFT engine. Each accepted sample is multiplied against the
//   twiddle of every bin and accumulated in parallel, so a full N-bin spectrum
//   is ready one cycle after the N-th sample of a frame. The result is held on
//   the outputs while the next frame accumulates.
//
// Ports
//   clk        : rising-edge clock
//   sreset     : synchronous active-high reset
//   in_valid   : sample present
//   in_ready   : engine accepts a sample (depends on state only)
//   in_re      : signed real part of the sample
//   in_im      : signed imaginary part (ignored in real mode)
//   cplx_mode  : 1 = complex input; captured on the first transfer of a frame
//   abort      : discard the partial frame (ignored during the latch cycle)
//   out_re[k]  : signed real part of bin k
//   out_im[k]  : signed imaginary part of bin k
//   done       : one-cycle pulse, outputs were just updated
// -----------------------------------------------------------------------------
module dft_stream #(
  parameter  int N      = 8,
  parameter  int DATA_W = 16,
  parameter  int TW_W   = 16,
  parameter  int SCALE  = 0,
  localparam int LOG2N  = $clog2(N),
  localparam int ACC_W  = DATA_W + LOG2N + 1
) (
  input  logic                     clk,
  input  logic                     sreset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  input  logic                     cplx_mode,
  input  logic                     abort,
  output logic signed [ACC_W-1:0]  out_re [N],
  output logic signed [ACC_W-1:0]  out_im [N],
  output logic                     done
);

  // Full-precision product-sum width: two DATA_W x TW_W products plus a carry.
  localparam int  P_W      = DATA_W + TW_W + 1;
  localparam int  ROUND_C  = 2 ** (TW_W - 2);
  localparam real TWO_PI   = 6.283185307179586;
  localparam real TW_SCALE = real'((2 ** (TW_W - 1)) - 1);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_LATCH = 1'b1
  } state_t;

  // Round half away from zero; used only at elaboration to build the table.
  function automatic int round_real(input real x);
    if (x >= 0.0) begin
      return $rtoi(x + 0.5);
    end else begin
      return -$rtoi(0.5 - x);
    end
  endfunction

  // Output scaling: optional arithmetic divide by N (floor toward -inf).
  function automatic logic signed [ACC_W-1:0] scale_out(input logic signed [ACC_W-1:0] a);
    if (SCALE != 0) begin
      return a >>> LOG2N;
    end else begin
      return a;
    end
  endfunction

  state_t                    state_q;
  logic                      ready_q;
  logic                      done_q;
  logic                      mode_q;
  logic [LOG2N-1:0]          n_q;
  logic signed [ACC_W-1:0]   acc_re_q [N];
  logic signed [ACC_W-1:0]   acc_im_q [N];
  logic signed [ACC_W-1:0]   out_re_q [N];
  logic signed [ACC_W-1:0]   out_im_q [N];

  logic signed [TW_W-1:0]    cos_tab [N];
  logic signed [TW_W-1:0]    sin_tab [N];
  logic signed [ACC_W-1:0]   inc_re_s [N];
  logic signed [ACC_W-1:0]   inc_im_s [N];

  logic                      cplx_eff_s;
  logic signed [DATA_W-1:0]  xr_s;
  logic signed [DATA_W-1:0]  xi_s;

  // Constant twiddle table, one cosine/sine pair per angle index.
  for (genvar m = 0; m < N; m++) begin : g_tw
    localparam int COS_V = round_real($cos(TWO_PI * real'(m) / real'(N)) * TW_SCALE);
    localparam int SIN_V = round_real($sin(TWO_PI * real'(m) / real'(N)) * TW_SCALE);
    assign cos_tab[m] = TW_W'(COS_V);
    assign sin_tab[m] = TW_W'(SIN_V);
  end

  // The mode register only becomes valid after the first transfer of a frame,
  // so that first transfer uses the live cplx_mode input directly.
  always_comb begin
    cplx_eff_s = (n_q == '0) ? cplx_mode : mode_q;
    xr_s       = in_re;
    if (cplx_eff_s) begin
      xi_s = in_im;
    end else begin
      xi_s = '0;
    end
  end

  // Per-bin rotated, rounded increment for the sample currently presented.
  for (genvar k = 0; k < N; k++) begin : g_bin
    localparam logic [LOG2N-1:0] K_IDX = LOG2N'(k);
    logic [LOG2N-1:0]       m_idx;
    logic signed [TW_W-1:0] c_s;
    logic signed [TW_W-1:0] s_s;
    logic signed [P_W-1:0]  p_re;
    logic signed [P_W-1:0]  p_im;
    logic signed [P_W-1:0]  r_re;
    logic signed [P_W-1:0]  r_im;

    // Angle index (k*n) mod N falls out of truncating the product to LOG2N bits.
    always_comb begin
      m_idx = K_IDX * n_q;
      c_s   = cos_tab[m_idx];
      s_s   = sin_tab[m_idx];
      p_re  = (P_W'(xr_s) * P_W'(c_s)) + (P_W'(xi_s) * P_W'(s_s));
      p_im  = (P_W'(xi_s) * P_W'(c_s)) - (P_W'(xr_s) * P_W'(s_s));
      r_re  = (p_re + P_W'(ROUND_C)) >>> (TW_W - 1);
      r_im  = (p_im + P_W'(ROUND_C)) >>> (TW_W - 1);
    end

    assign inc_re_s[k] = ACC_W'(r_re);
    assign inc_im_s[k] = ACC_W'(r_im);
  end

  // Frame FSM, accumulators and registered outputs.
  always_ff @(posedge clk) begin
    if (sreset) begin
      state_q <= ST_ACCUM;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      mode_q  <= 1'b0;
      n_q     <= '0;
      for (int k = 0; k < N; k++) begin
        acc_re_q[k] <= '0;
        acc_im_q[k] <= '0;
        out_re_q[k] <= '0;
        out_im_q[k] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_ACCUM: begin
          if (abort) begin
            // Abort wins over a simultaneous transfer; outputs keep last result.
            n_q <= '0;
            for (int k = 0; k < N; k++) begin
              acc_re_q[k] <= '0;
              acc_im_q[k] <= '0;
            end
          end else if (in_valid && ready_q) begin
            for (int k = 0; k < N; k++) begin
              acc_re_q[k] <= acc_re_q[k] + inc_re_s[k];
              acc_im_q[k] <= acc_im_q[k] + inc_im_s[k];
            end
            if (n_q == '0) begin
              mode_q <= cplx_mode;
            end
            if (n_q == LOG2N'(N - 1)) begin
              state_q <= ST_LATCH;
              ready_q <= 1'b0;
            end
            n_q <= n_q + 1'b1;
          end
        end
        ST_LATCH: begin
          for (int k = 0; k < N; k++) begin
            out_re_q[k] <= scale_out(acc_re_q[k]);
            out_im_q[k] <= scale_out(acc_im_q[k]);
            acc_re_q[k] <= '0;
            acc_im_q[k] <= '0;
          end
          n_q     <= '0;
          done_q  <= 1'b1;
          state_q <= ST_ACCUM;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_ACCUM;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready = ready_q;
  assign done     = done_q;
  assign out_re   = out_re_q;
  assign out_im   = out_im_q;

endmodule

// File: tb/tb_dft_stream.sv
// -----------------------------------------------------------------------------
// tb_dft_stream
//   Directed bench for dft_stream, N=8, 16-bit data and twiddles. Two DUTs share
//   the stimulus: one unscaled, one with SCALE=1.
// -----------------------------------------------------------------------------
module tb_dft_stream;

  localparam int N     = 8;
  localparam int ACC_W = 20;

  logic               clk = 1'b0;
  logic               sreset;
  logic               in_valid;
  logic signed [15:0] in_re;
  logic signed [15:0] in_im;
  logic               cplx_mode;
  logic               abort;
  logic               rdy0, rdy1, done0, done1;
  logic signed [ACC_W-1:0] o_re0 [N];
  logic signed [ACC_W-1:0] o_im0 [N];
  logic signed [ACC_W-1:0] o_re1 [N];
  logic signed [ACC_W-1:0] o_im1 [N];

  int total = 0;
  int bad   = 0;
  int ready_low_cnt = 0;
  int done_cnt      = 0;

  dft_stream #(.N(N), .DATA_W(16), .TW_W(16), .SCALE(0)) dut0 (
    .clk(clk), .sreset(sreset), .in_valid(in_valid), .in_ready(rdy0),
    .in_re(in_re), .in_im(in_im), .cplx_mode(cplx_mode), .abort(abort),
    .out_re(o_re0), .out_im(o_im0), .done(done0)
  );

  dft_stream #(.N(N), .DATA_W(16), .TW_W(16), .SCALE(1)) dut1 (
    .clk(clk), .sreset(sreset), .in_valid(in_valid), .in_ready(rdy1),
    .in_re(in_re), .in_im(in_im), .cplx_mode(cplx_mode), .abort(abort),
    .out_re(o_re1), .out_im(o_im1), .done(done1)
  );

  always #5 clk = ~clk;

  // Count stall cycles and done pulses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!sreset && !rdy0) ready_low_cnt++;
    if (done0) done_cnt++;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input longint obs, input longint exp, input longint tol);
    total++;
    assert ((obs - exp) <= tol && (exp - obs) <= tol) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, exp, tol);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transfer; waits (bounded) for in_ready, then lets the edge take it.
  task automatic xfer(input int re, input int im);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_re    = 16'(re);
    in_im    = 16'(im);
    while (!rdy0 && w < 20) begin
      step();
      w++;
    end
    if (!rdy0) chk("ready_timeout", 0, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int re[N], input int im[N], input bit cplx, input bit gaps);
    cplx_mode = cplx;
    for (int i = 0; i < N; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step();
      xfer(re[i], im[i]);
    end
  endtask

  // Called right after the last transfer edge: checks latch/done timing.
  task automatic wait_done(input string tag);
    chk({tag, "_ready_latch"}, longint'(rdy0), 0);
    chk({tag, "_done_early"}, longint'(done0), 0);
    step();
    chk({tag, "_done_pulse"}, longint'(done0), 1);
    chk({tag, "_ready_back"}, longint'(rdy0), 1);
  endtask

  int imp_re[N]  = '{1000, 0, 0, 0, 0, 0, 0, 0};
  int junk_im[N] = '{777, -555, 123, 4000, -1, 9, 300, -3000};
  int zero_v[N]  = '{0, 0, 0, 0, 0, 0, 0, 0};
  int dc_re[N]   = '{100, 100, 100, 100, 100, 100, 100, 100};
  int alt_re[N]  = '{100, -100, 100, -100, 100, -100, 100, -100};
  int tone_re[N] = '{1000, 707, 0, -707, -1000, -707, 0, 707};
  int tone_im[N] = '{0, 707, 1000, 707, 0, -707, -1000, -707};

  initial begin
    sreset = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0;
    cplx_mode = 1'b0; abort = 1'b0;
    repeat (3) step();
    sreset = 1'b0;
    step();

    // Reset state.
    chk("rst_ready", longint'(rdy0), 1);
    chk("rst_ready_s1", longint'(rdy1), 1);
    chk("rst_done", longint'(done0), 0);
    chk("rst_re0", o_re0[0], 0);
    chk("rst_im7", o_im0[7], 0);

    // Impulse, real mode with garbage imaginary input that must be ignored.
    send_frame(imp_re, junk_im, 1'b0, 1'b0);
    wait_done("imp");
    for (int k = 0; k < N; k++) begin
      chk($sformatf("imp_re%0d", k), o_re0[k], 1000);
      chk($sformatf("imp_im%0d", k), o_im0[k], 0);
    end
    chk("imp_s1_re0", o_re1[0], 125);
    step();
    chk("imp_done_fall", longint'(done0), 0);

    // DC.
    send_frame(dc_re, zero_v, 1'b0, 1'b0);
    wait_done("dc");
    chk("dc_re0", o_re0[0], 800);
    for (int k = 1; k < N; k++) begin
      chk_tol($sformatf("dc_re%0d", k), o_re0[k], 0, 1);
      chk_tol($sformatf("dc_im%0d", k), o_im0[k], 0, 1);
    end

    // Alternating sign -> Nyquist bin; scaled DUT gives 800/8.
    send_frame(alt_re, zero_v, 1'b0, 1'b0);
    wait_done("alt");
    chk("alt_re4", o_re0[4], 800);
    chk("alt_s1_re4", o_re1[4], 100);
    chk_tol("alt_re0", o_re0[0], 0, 1);
    chk_tol("alt_im4", o_im0[4], 0, 1);
    chk_tol("alt_re2", o_re0[2], 0, 1);

    // Complex tone at bin 1.
    send_frame(tone_re, tone_im, 1'b1, 1'b0);
    wait_done("tone");
    chk_tol("tone_re1", o_re0[1], 8000, 4);
    chk_tol("tone_im1", o_im0[1], 0, 4);
    for (int k = 0; k < N; k++) begin
      if (k != 1) begin
        chk_tol($sformatf("tone_re%0d", k), o_re0[k], 0, 4);
        chk_tol($sformatf("tone_im%0d", k), o_im0[k], 0, 4);
      end
    end

    // Handshake: DC then alternating, random gaps, second frame back-to-back.
    step();
    ready_low_cnt = 0;
    done_cnt      = 0;
    send_frame(dc_re, zero_v, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 2)) step();
      xfer(alt_re[i], 0);
    end
    chk("hs_done_cnt_a", done_cnt, 1);
    chk("hs_held_re0", o_re0[0], 800);
    for (int i = 4; i < N; i++) begin
      repeat ($urandom_range(0, 2)) step();
      xfer(alt_re[i], 0);
    end
    wait_done("hs_b");
    chk("hs_b_re4", o_re0[4], 800);
    chk_tol("hs_b_re0", o_re0[0], 0, 1);
    step();
    chk("hs_ready_low", ready_low_cnt, 2);
    chk("hs_done_cnt_b", done_cnt, 2);

    // Abort after 5 samples (simultaneous transfer discarded), then impulse.
    done_cnt = 0;
    for (int i = 0; i < 5; i++) xfer(500, 0);
    abort = 1'b1;
    xfer(500, 0);
    abort = 1'b0;
    chk("abort_held_re4", o_re0[4], 800);
    chk("abort_no_done", done_cnt, 0);
    send_frame(imp_re, zero_v, 1'b0, 1'b0);
    wait_done("abort_imp");
    for (int k = 0; k < N; k++) begin
      chk($sformatf("abort_re%0d", k), o_re0[k], 1000);
      chk($sformatf("abort_im%0d", k), o_im0[k], 0);
    end

    // Reset mid-frame clears outputs; next frame is clean.
    step();
    for (int i = 0; i < 3; i++) xfer(300, 0);
    sreset = 1'b1;
    abort  = 1'b1;
    step();
    sreset = 1'b0;
    abort  = 1'b0;
    chk("srst_done", longint'(done0), 0);
    chk("srst_ready", longint'(rdy0), 1);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("srst_re%0d", k), o_re0[k], 0);
    end
    chk("srst_im0", o_im0[0], 0);
    send_frame(dc_re, zero_v, 1'b0, 1'b0);
    wait_done("srst_dc");
    chk("srst_dc_re0", o_re0[0], 800);
    chk_tol("srst_dc_re3", o_re0[3], 0, 1);
    chk("srst_dc_s1_re0", o_re1[0], 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dft_stream.md
# dft_stream

Parametrised streaming direct DFT engine: accepts one complex (or real) sample per handshake, accumulates it into all N frequency bins in parallel against an internal twiddle table, and presents the full N-bin spectrum with a one-cycle `done` pulse after every N-th accepted sample. It is the generalised successor to the fixed 64-point engine: point count, data width, twiddle precision and output scaling are parameters, and it adds a valid/ready input handshake, a frame-abort and real/complex input mode. It sits between the sample front-end and the spectral post-processing stage.

## Interface
- `N`, 8: points per frame; power of two, 8..64.
- `DATA_W`, 16: signed input sample width.
- `TW_W`, 16: signed twiddle width; twiddle magnitude scale 2^(TW_W-1)-1.
- `SCALE`, 0: 1 = outputs divided by N (arithmetic shift right by log2(N)).
- Derived: `ACC_W` = DATA_W + log2(N) + 1.

- `clk` in 1: single clock, all logic rising-edge.
- `sreset` in 1: synchronous, active-high reset.
- `in_valid` in 1: sample present.
- `in_ready` out 1: engine can accept; a sample transfers on an edge where both are high.
- `in_re` in DATA_W: signed real part.
- `in_im` in DATA_W: signed imaginary part; treated as 0 when `cplx_mode`=0.
- `cplx_mode` in 1: sampled at the first accepted sample of a frame, held for the frame.
- `abort` in 1: discard partial frame.
- `out_re[0:N-1]` out ACC_W each: signed real part of bin k.
- `out_im[0:N-1]` out ACC_W each: signed imaginary part of bin k.
- `done` out 1: one-cycle pulse, outputs just updated.

## Operation
- Transform: X[k] = sum over n of x[n]·e^(-j2πkn/N), n = index of accepted sample within frame (0..N-1).
- Twiddle table: N entries, C[m] = round(cos(2πm/N)·(2^(TW_W-1)-1)), S[m] = round(sin(2πm/N)·(2^(TW_W-1)-1)); bin k, sample n uses m = (k·n) mod N.
- Per-bin update per accepted sample: re_acc[k] += R(xr·C + xi·S), im_acc[k] += R(xi·C − xr·S); R(p) = (p + 2^(TW_W-2)) >>> (TW_W-1), arithmetic.
- Accumulators ACC_W bits; width guarantees no overflow for any input, no saturation logic.
- Output value: acc (SCALE=0) or acc >>> log2(N) (SCALE=1, truncating toward −inf), sign-extended to ACC_W.
- States: ACCUM (in_ready=1, counting n 0..N-1), LATCH (in_ready=0, one cycle).
- ACCUM: each transfer updates all bins and increments n; transfer with n=N-1 → LATCH.
- LATCH: out_* ← scaled accumulators, accumulators ← 0, n ← 0, done ← 1; → ACCUM.
- Outputs hold their value until the next LATCH; next frame accumulates while previous result is held.
- `abort` in ACCUM: accumulators and n cleared on that edge; any simultaneous transfer is discarded; outputs untouched. `abort` in LATCH ignored (frame completes).
- `in_valid` low in ACCUM: no change (gaps allowed anywhere in a frame).
- `sreset`: state ACCUM, n=0, accumulators 0, all out_re/out_im 0, done 0; in_ready=1 from the first cycle after reset deasserts. Reset mid-frame discards the frame; reset has priority over abort and transfers.

## Timing
- Accumulator update: registered on the transfer edge.
- Last sample transferred on edge E: in_ready low during cycle E..E+1; outputs and done=1 visible after edge E+1; done low after E+2 unless another frame completes.
- Back-to-back: sustained throughput N samples per N+1 cycles.
- in_ready depends only on state (no combinational path from in_valid).
- cplx_mode change mid-frame has no effect until the next frame's first transfer.

## Test plan
- N=8, DATA_W=TW_W=16, SCALE=0: impulse in_re={1000,0,0,0,0,0,0,0}, real mode → done one edge after last transfer; every out_re[k]=1000, every out_im[k]=0.
- DC: 8×in_re=100 → out_re[0]=800, all other bins |re|,|im| ≤ 1.
- Alternating +100/−100 → out_re[4]=800, others |re|,|im| ≤ 1; repeat with SCALE=1 → out_re[4]=100.
- Complex tone x[n]=round(1000·e^(j2πn/8)), cplx_mode=1 → out_re[1] within 8000±4, all other bins |re|,|im| ≤ 4.
- Handshake: random in_valid gaps, two back-to-back frames → in_ready low exactly one cycle per frame, results match gap-free run, first frame's outputs held while second accumulates.
- Abort after 5 samples then full impulse frame → result identical to clean impulse frame; sreset asserted mid-frame → all outputs 0, done 0, next full frame correct.
